// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU sequencer (32-step restoring divide, HI/LO result)
module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [63:0] r_w;
  logic [31:0] r_d;
  logic [31:0] r_dividend;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_result;
  logic        r_ready;

  logic        w_accept;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_top;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [63:0] w_w_iter;
  logic        w_last;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_accept = start & ~annul;
  assign w_mag1   = (signed_div & opdata1[31]) ? (32'd0 - opdata1) : opdata1;
  assign w_mag2   = (signed_div & opdata2[31]) ? (32'd0 - opdata2) : opdata2;

  // Partial remainder after the shift can reach 33 bits, so keep W[63] in the compare.
  assign w_top    = r_w[63:31];
  assign w_diff   = w_top - {1'b0, r_d};
  assign w_ge     = (w_top >= {1'b0, r_d});
  assign w_w_iter = w_ge ? {w_diff[31:0], r_w[30:0], 1'b1} : {r_w[62:0], 1'b0};
  assign w_last   = (r_cnt == 6'd31);

  assign w_quo = r_neg_q ? (32'd0 - w_w_iter[31:0])  : w_w_iter[31:0];
  assign w_rem = r_neg_r ? (32'd0 - w_w_iter[63:32]) : w_w_iter[63:32];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (opdata2 == 32'd0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        w_state_nxt = annul ? S_IDLE : S_END;
      end
      S_ON: begin
        if (annul) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    stall = (((r_state == S_IDLE) & start) | (r_state == S_ON) | (r_state == S_BYZERO)) & ~annul;
  end

  // Result and ready are loaded on the edge entering END so both are valid during END.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt      <= 6'd0;
      r_w        <= 64'd0;
      r_d        <= 32'd0;
      r_dividend <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= 64'd0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt      <= 6'd0;
            r_w        <= {32'd0, w_mag1};
            r_d        <= w_mag2;
            r_dividend <= opdata1;
            r_neg_q    <= signed_div & (opdata1[31] ^ opdata2[31]);
            r_neg_r    <= signed_div & opdata1[31];
          end
        end
        S_ON: begin
          if (!annul) begin
            r_w   <= w_w_iter;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              r_result <= {w_rem, w_quo};
              r_ready  <= 1'b1;
            end
          end
        end
        S_BYZERO: begin
          if (!annul) begin
            r_result <= {r_dividend, 32'hFFFF_FFFF};
            r_ready  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;
  assign ready  = r_ready;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - randomized and directed bench for div_ctrl against an arithmetic model
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_last;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall      (stall)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] rq;
    if (b == 32'd0) begin
      rq = {a, 32'hFFFF_FFFF};
    end else begin
      sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
      q  = sa / sb;
      r  = sa % sb;
      rq = {r[31:0], q[31:0]};
    end
    return rq;
  endfunction

  // One operation starting in cycle 0; annul_at < 0 means run to completion.
  task automatic div_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input int annul_at);
    int          ncyc;
    int          exp_lat;
    int          ready_cyc;
    int          n_ready;
    int          stall_err;
    logic        exp_stall;
    logic [63:0] exp_res;
    logic [63:0] res_at_ready;
    exp_res      = model(a, b, sg);
    exp_lat      = (b == 32'd0) ? 2 : 33;
    ncyc         = (annul_at >= 0) ? annul_at + 1 : 40;
    ready_cyc    = -1;
    n_ready      = 0;
    stall_err    = -1;
    res_at_ready = '0;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0);
      annul = (c == annul_at);
      if (c == 0) begin
        opdata1    = a;
        opdata2    = b;
        signed_div = sg;
      end else begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom);
      end
      #1;
      exp_stall = (annul_at >= 0) ? (c < annul_at) : (c < exp_lat);
      if (stall !== exp_stall && stall_err < 0) stall_err = c;
      if (ready === 1'b1) begin
        n_ready++;
        if (ready_cyc < 0) begin
          ready_cyc    = c;
          res_at_ready = result;
        end
      end
      next_cycle();
    end
    start = 1'b0;
    annul = 1'b0;
    chk({tag, " stall_first_bad_cycle"}, 64'(stall_err), 64'(-1));
    if (annul_at < 0) begin
      chk({tag, " ready_cycle"}, 64'(ready_cyc), 64'(exp_lat));
      chk({tag, " ready_count"}, 64'(n_ready), 64'(1));
      chk({tag, " result"}, res_at_ready, exp_res);
      exp_last = exp_res;
    end else begin
      chk({tag, " ready_count_annulled"}, 64'(n_ready), 64'(0));
    end
    chk({tag, " result_hold"}, result, exp_last);
  endtask

  initial begin
    int          n_ready;
    int          rc1;
    int          rc2;
    logic [63:0] res1;
    logic [63:0] res2;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        stall33;
    logic        stall34;

    resetn     = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    exp_last   = 64'd0;
    next_cycle();
    next_cycle();
    chk("reset result", result, 64'd0);
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    resetn = 1'b1;

    div_op("u100_7", 32'd100, 32'd7, 1'b0, -1);
    chk("u100_7 const", result, 64'h00000002_0000000E);
    div_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, -1);
    chk("s_m7_2 const", result, 64'hFFFFFFFF_FFFFFFFD);
    div_op("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    chk("u_m7_2 const", result, 64'h00000001_7FFFFFFC);
    div_op("s5_0", 32'd5, 32'd0, 1'b1, -1);
    chk("s5_0 const", result, 64'h00000005_FFFFFFFF);
    div_op("u5_0", 32'd5, 32'd0, 1'b0, -1);
    chk("u5_0 const", result, 64'h00000005_FFFFFFFF);
    div_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
    chk("s_ovf const", result, 64'h00000000_80000000);

    div_op("seq_100_7", 32'd100, 32'd7, 1'b0, -1);
    div_op("seq_annul", 32'd12345, 32'd11, 1'b0, 10);
    chk("seq_annul kept", result, 64'h00000002_0000000E);
    div_op("seq_9_3", 32'd9, 32'd3, 1'b0, -1);
    chk("seq_9_3 const", result, 64'h00000000_00000003);

    start   = 1'b1;
    annul   = 1'b1;
    opdata1 = 32'd50;
    opdata2 = 32'd5;
    #1;
    chk("start_annul stall", 64'(stall), 64'd0);
    next_cycle();
    start   = 1'b0;
    annul   = 1'b0;
    n_ready = 0;
    for (int c = 0; c < 36; c++) begin
      if (ready === 1'b1) n_ready++;
      next_cycle();
    end
    chk("start_annul ready_count", 64'(n_ready), 64'd0);
    chk("start_annul result", result, exp_last);

    opdata1    = 32'd12345;
    opdata2    = 32'd17;
    signed_div = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      start  = (c == 0);
      resetn = (c != 20);
      next_cycle();
    end
    resetn = 1'b1;
    #1;
    chk("midreset result", result, 64'd0);
    chk("midreset ready", 64'(ready), 64'd0);
    chk("midreset stall", 64'(stall), 64'd0);
    exp_last = 64'd0;
    n_ready  = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready === 1'b1) n_ready++;
      next_cycle();
    end
    chk("midreset no_ready", 64'(n_ready), 64'd0);
    div_op("u_ffff_1", 32'hFFFF_FFFF, 32'd1, 1'b0, -1);
    chk("u_ffff_1 const", result, 64'h00000000_FFFFFFFF);

    n_ready = 0;
    rc1     = -1;
    rc2     = -1;
    res1    = '0;
    res2    = '0;
    stall33 = 1'b0;
    stall34 = 1'b0;
    for (int c = 0; c < 72; c++) begin
      start      = (c <= 34);
      signed_div = 1'b0;
      opdata1    = (c < 34) ? 32'd1000 : 32'd77;
      opdata2    = (c < 34) ? 32'd10 : 32'd5;
      #1;
      if (c == 33) stall33 = stall;
      if (c == 34) stall34 = stall;
      if (ready === 1'b1) begin
        n_ready++;
        if (rc1 < 0) begin
          rc1  = c;
          res1 = result;
        end else if (rc2 < 0) begin
          rc2  = c;
          res2 = result;
        end
      end
      next_cycle();
    end
    start = 1'b0;
    chk("held ready1_cycle", 64'(rc1), 64'd33);
    chk("held ready2_cycle", 64'(rc2), 64'd67);
    chk("held ready_count", 64'(n_ready), 64'd2);
    chk("held stall_end", 64'(stall33), 64'd0);
    chk("held stall_reaccept", 64'(stall34), 64'd1);
    chk("held result1", res1, model(32'd1000, 32'd10, 1'b0));
    chk("held result2", res2, model(32'd77, 32'd5, 1'b0));
    exp_last = res2;

    for (int i = 0; i < 25; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      div_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide sequencer for the execute stage, handling MIPS DIV/DIVU. It accepts a start request from EX and stalls the pipeline while it runs a 32-iteration restoring shift-subtract loop. It then delivers a 64-bit {remainder, quotient} result for the HI/LO write-back. It sits beside the combinational ALU and owns the only multi-cycle arithmetic path in the core.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  EX requests a divide; sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; latched with start.
- annul  in  1  flush from exception/branch; cancels a running divide.
- opdata1  in  32  dividend; latched on accepted start.
- opdata2  in  32  divisor; latched on accepted start.
- result  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
- ready  out  1  one-cycle pulse, result valid.
- stall  out  1  combinational pipeline stall request.

## Operation
- States: IDLE, BYZERO, ON, END; 6-bit iteration counter cnt; 64-bit work register W; 32-bit divisor register D; latched sign flags.
- IDLE:
  - start=1 and annul=0 accepts the divide.
  - opdata2==0 -> BYZERO.
  - Otherwise -> ON with cnt=0. W={32'b0, |opdata1|} and D=|opdata2|, where |x| is the two's-complement magnitude if signed_div=1 and x is raw otherwise.
  - Also latched: neg_q = signed_div & (opdata1[31]^opdata2[31]), neg_r = signed_div & opdata1[31], and the raw dividend.
- ON, one iteration per cycle:
  - W<=W<<1.
  - If shifted W[63:32] >= D (33-bit unsigned compare), subtract D from W[63:32] and set W[0]=1.
  - cnt++.
  - After the 32nd iteration (cnt reaches 32) -> END.
- END:
  - result <= {neg_r ? -W[63:32] : W[63:32], neg_q ? -W[31:0] : W[31:0]}.
  - ready=1.
  - Next state IDLE.
- BYZERO: next state END with forced values quotient=32'hFFFF_FFFF and remainder=latched raw dividend, independent of signed_div.
- Overflow case: signed 32'h8000_0000 / 32'hFFFF_FFFF yields quotient 32'h8000_0000 (wrap) and remainder 0. No trap is raised.
- annul=1 in ON or BYZERO -> IDLE next cycle. ready is never asserted for that operation and result keeps its previous value.
- annul in END has no effect; the result completes.
- Operand changes after acceptance are ignored.
- result holds its value until the next END; it is not cleared on IDLE.

## Timing
- Reset (resetn=0 at an edge): state=IDLE, cnt=0, W=0, D=0, result=0, ready=0. stall=0 whenever start=0. This applies mid-operation too, with no completion.
- stall = ((state==IDLE & start) | state==ON | state==BYZERO) & ~annul; stall=0 in END.
- Normal divide:
  - Start accepted at cycle 0.
  - ON during cycles 1..32.
  - END/ready at cycle 33.
  - stall high cycles 0..32.
- Divide by zero: start at cycle 0, BYZERO at cycle 1, ready at cycle 2. stall is high at cycles 0..1.
- In the END cycle the pipeline advances. A start seen in END is ignored; the next start is accepted in the following IDLE cycle at the earliest, giving back-to-back throughput of one divide per 34 cycles.
- start and annul together in IDLE: not accepted, stall=0.

## Test plan
- Unsigned 100/7 -> ready at cycle 33; result={32'h2, 32'hE}; stall high exactly cycles 0..32.
- Signed -7/2 (32'hFFFF_FFF9 / 32'h2) -> result={32'hFFFF_FFFF, 32'hFFFF_FFFD}. The same operands with DIVU -> quotient 32'h7FFF_FFFC, remainder 32'h1.
- 5/0, signed and unsigned -> ready at cycle 2; result={32'h5, 32'hFFFF_FFFF}. Signed 32'h8000_0000/32'hFFFF_FFFF -> result={32'h0, 32'h8000_0000}.
- Sequence: divide 100/7, then a second divide annulled at cycle 10. Required response: stall=0 in the annul cycle, IDLE next cycle, no ready pulse, and result still {2, 14}. A third divide, 9/3, started immediately after -> {32'h0, 32'h3}.
- resetn=0 at cycle 20 of a divide -> result=0, ready=0, stall=0 next cycle; no ready appears afterward. A new 32'hFFFF_FFFF/1 unsigned after reset -> {32'h0, 32'hFFFF_FFFF}.
- start held high through END -> exactly one ready pulse, and the second start is accepted in IDLE after END, not during it.
